// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx / sipo serial link.
package piso_pkg;

  // State encoding for the transmitter FSM.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Default word width; sipo benches use the same value.
  localparam int unsigned SER_WIDTH = 4;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } piso_state_e;

  // Bit counter width for a given word length (never below one bit).
  function automatic int unsigned cnt_bits(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. Accepts a word on a valid/ready
// handshake and shifts it out LSB-first, one bit per enabled clock.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             enable,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CntW = cnt_bits(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;

  // Ready depends only on state and reset, never on load_valid.
  assign load_ready = (state_q == StIdle) && !rst;

  // Next-state, shift and count logic; outputs are precomputed from next state.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_valid && load_ready) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (enable) begin
          sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Registering from next state keeps sout aligned with sreg without a comb output path.
    sout_valid_d = (state_d == StShift);
    sout_d       = sout_valid_d & sreg_d[0];
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx with a behavioural sipo receiver model.
module tb_piso_tx;
  import piso_pkg::*;

  localparam int unsigned W = SER_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         enable;
  logic         sout;
  logic         sout_valid;
  logic         done;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .enable     (enable),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Receiver model: sipo shifting right with sin entering the MSB.
  logic [W-1:0] rx_word;
  always @(posedge clk) begin
    if (rst) rx_word <= '0;
    else if (sout_valid && enable) rx_word <= {sout, rx_word[W-1:1]};
  end

  int checks = 0;
  int fails  = 0;

  // Scoreboard: expected bits/words pushed when a load is driven.
  logic         exp_bits[$];
  logic [W-1:0] exp_words[$];

  // Observations gathered while cycles are run.
  logic         obs_bits[$];
  logic [W-1:0] rx_seen[$];
  int           starts[$];
  logic [31:0]  en_pat;
  logic         sout_trace[32];
  int           iter, obs_dones, done_at, valid_cycles;
  logic         valid_at_done, ready_at_done, prev_valid;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_obs();
    obs_bits.delete();
    rx_seen.delete();
    starts.delete();
    iter = 0;
    obs_dones = 0;
    done_at = -1;
    valid_cycles = 0;
    valid_at_done = 1'b0;
    ready_at_done = 1'b0;
    prev_valid = 1'b0;
    for (int i = 0; i < 32; i++) sout_trace[i] = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      enable = (iter < 32) ? en_pat[iter] : 1'b1;
      if (iter < 32) sout_trace[iter] = sout;
      if (sout_valid && !prev_valid) starts.push_back(iter);
      if (sout_valid) valid_cycles++;
      prev_valid = sout_valid;
      if (sout_valid && enable) obs_bits.push_back(sout);
      if (done) begin
        obs_dones++;
        done_at = iter;
        valid_at_done = sout_valid;
        ready_at_done = load_ready;
        rx_seen.push_back(rx_word);
      end
      iter++;
      cycle();
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int b = 0; b < int'(W); b++) exp_bits.push_back(w[b]);
    exp_words.push_back(w);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; enable = 1'b0; din = '0; en_pat = '1;
    cycle();
    cycle();
    checks++;
    if (load_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_rst: got %b expected 0", load_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (sout !== 1'b0) begin fails++; $display("FAIL reset_sout: got %b expected 0", sout); end
    checks++;
    if (sout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", sout_valid); end
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
    cycle();
  endtask

  task automatic test_basic_frame();
    din = 4'b1011; load_valid = 1'b1; enable = 1'b1; en_pat = '1;
    checks++;
    if (load_ready !== 1'b1) begin fails++; $display("FAIL basic_accept_ready: got %b expected 1", load_ready); end
    push_word(4'b1011);
    cycle();
    load_valid = 1'b0; din = '0;
    begin_obs();
    run_cycles(7);
    checks++;
    if (obs_bits.size() != int'(W)) begin fails++; $display("FAIL basic_bit_count: got %0d expected %0d", obs_bits.size(), W); end
    while (exp_bits.size() > 0) begin
      logic e, o;
      e = exp_bits.pop_front();
      o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL basic_bit: got %b expected %b", o, e); end
    end
    checks++;
    if (obs_dones != 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", obs_dones); end
    checks++;
    if (done_at != 4) begin fails++; $display("FAIL basic_done_cycle: got %0d expected 4", done_at); end
    checks++;
    if (valid_at_done !== 1'b0 || ready_at_done !== 1'b1) begin
      fails++; $display("FAIL basic_done_flags: got valid=%b ready=%b expected valid=0 ready=1", valid_at_done, ready_at_done);
    end
    while (exp_words.size() > 0) begin
      logic [W-1:0] ew, ow;
      ew = exp_words.pop_front();
      ow = (rx_seen.size() > 0) ? rx_seen.pop_front() : 'x;
      checks++;
      if (ow !== ew) begin fails++; $display("FAIL basic_rx_word: got %h expected %h", ow, ew); end
    end
  endtask

  task automatic test_gated_enable();
    din = 4'hA; load_valid = 1'b1; enable = 1'b1;
    push_word(4'hA);
    cycle();
    load_valid = 1'b0; din = '0;
    en_pat = 32'hFFFF_FFD9; // 1,0,0,1,1,0,1 then all ones
    begin_obs();
    run_cycles(10);
    checks++;
    if (sout_trace[1] !== 1'b1 || sout_trace[2] !== 1'b1 || sout_trace[5] !== 1'b1) begin
      fails++; $display("FAIL gated_hold: got %b%b%b expected 111", sout_trace[1], sout_trace[2], sout_trace[5]);
    end
    while (exp_bits.size() > 0) begin
      logic e, o;
      e = exp_bits.pop_front();
      o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL gated_bit: got %b expected %b", o, e); end
    end
    checks++;
    if (obs_dones != 1 || done_at != 7) begin
      fails++; $display("FAIL gated_done: got count=%0d at=%0d expected count=1 at=7", obs_dones, done_at);
    end
    while (exp_words.size() > 0) begin
      logic [W-1:0] ew, ow;
      ew = exp_words.pop_front();
      ow = (rx_seen.size() > 0) ? rx_seen.pop_front() : 'x;
      checks++;
      if (ow !== ew) begin fails++; $display("FAIL gated_rx_word: got %h expected %h", ow, ew); end
    end
    en_pat = '1;
  endtask

  task automatic test_load_while_busy();
    din = 4'h3; load_valid = 1'b1; enable = 1'b1; en_pat = '1;
    push_word(4'h3);
    cycle();
    din = 4'h5; // stays valid while the frame is in flight
    begin_obs();
    run_cycles(3);
    load_valid = 1'b0; din = '0;
    run_cycles(8);
    checks++;
    if (obs_dones != 1 || valid_cycles != int'(W)) begin
      fails++; $display("FAIL busy_extra_frame: got dones=%0d valid=%0d expected dones=1 valid=%0d", obs_dones, valid_cycles, W);
    end
    checks++;
    if (obs_bits.size() != int'(W)) begin fails++; $display("FAIL busy_bit_count: got %0d expected %0d", obs_bits.size(), W); end
    while (exp_bits.size() > 0) begin
      logic e, o;
      e = exp_bits.pop_front();
      o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL busy_bit: got %b expected %b", o, e); end
    end
    while (exp_words.size() > 0) begin
      logic [W-1:0] ew, ow;
      ew = exp_words.pop_front();
      ow = (rx_seen.size() > 0) ? rx_seen.pop_front() : 'x;
      checks++;
      if (ow !== ew) begin fails++; $display("FAIL busy_rx_word: got %h expected %h", ow, ew); end
    end
  endtask

  task automatic test_reset_mid_frame();
    din = 4'h6; load_valid = 1'b1; enable = 1'b1; en_pat = '1;
    push_word(4'h6);
    cycle();
    load_valid = 1'b0; din = '0;
    begin_obs();
    run_cycles(2);
    rst = 1'b1; enable = 1'b1;
    cycle();
    checks++;
    if (sout_valid !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs: got valid=%b done=%b expected 0 0", sout_valid, done);
    end
    checks++;
    if (load_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready_in_rst: got %b expected 0", load_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready_after: got %b expected 1", load_ready); end
    run_cycles(6);
    checks++;
    if (obs_dones != 0) begin fails++; $display("FAIL midrst_done: got %0d expected 0", obs_dones); end
    checks++;
    if (obs_bits.size() != 2) begin fails++; $display("FAIL midrst_bit_count: got %0d expected 2", obs_bits.size()); end
    for (int b = 0; b < 2; b++) begin
      logic e, o;
      e = exp_bits.pop_front();
      o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL midrst_bit: got %b expected %b", o, e); end
    end
    // Aborted frame: the remaining expectations are discarded.
    exp_bits.delete();
    exp_words.delete();
  endtask

  task automatic test_back_to_back();
    din = 4'h3; load_valid = 1'b1; enable = 1'b1; en_pat = '1;
    checks++;
    if (load_ready !== 1'b1) begin fails++; $display("FAIL b2b_accept_ready: got %b expected 1", load_ready); end
    push_word(4'h3);
    cycle();
    din = 4'hC;
    push_word(4'hC);
    begin_obs();
    run_cycles(5);
    load_valid = 1'b0; din = '0;
    run_cycles(8);
    checks++;
    if (starts.size() != 2) begin
      fails++; $display("FAIL b2b_frame_count: got %0d expected 2", starts.size());
    end else begin
      checks++;
      if (starts[1] - starts[0] != int'(W) + 1) begin
        fails++; $display("FAIL b2b_period: got %0d expected %0d", starts[1] - starts[0], W + 1);
      end
    end
    checks++;
    if (obs_dones != 2 || done_at != 9) begin
      fails++; $display("FAIL b2b_done: got count=%0d at=%0d expected count=2 at=9", obs_dones, done_at);
    end
    while (exp_bits.size() > 0) begin
      logic e, o;
      e = exp_bits.pop_front();
      o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL b2b_bit: got %b expected %b", o, e); end
    end
    while (exp_words.size() > 0) begin
      logic [W-1:0] ew, ow;
      ew = exp_words.pop_front();
      ow = (rx_seen.size() > 0) ? rx_seen.pop_front() : 'x;
      checks++;
      if (ow !== ew) begin fails++; $display("FAIL b2b_rx_word: got %h expected %h", ow, ew); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gated_enable();
    test_load_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter, the sending end of the team's 4-bit `sipo` serial link. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out LSB-first, one bit per enabled clock. It drives a strobe so that a downstream `sipo`, with its enable tied to `sout_valid & enable`, reassembles the original word unchanged.

## Interface
- `WIDTH`, default 4: word length in bits; legal range WIDTH ≥ 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `din` in WIDTH: parallel word; sampled only on an accepted load.
- `load_valid` in 1: `din` is valid.
- `load_ready` out 1: the block can accept a load.
- `enable` in 1: bit strobe; the current bit is consumed at this edge when `sout_valid` is also high.
- `sout` out 1: serial data, LSB first.
- `sout_valid` out 1: a frame is in progress and `sout` carries a live bit.
- `done` out 1: single-cycle pulse marking the end of a frame.

## Operation
- State machine with two states: IDLE and SHIFT.
- Registers:
  - shift register `sreg[WIDTH-1:0]`
  - bit counter `cnt`, width `$clog2(WIDTH)`
  - `done` flag
- Reset (`rst` high at an edge):
  - state goes to IDLE; `sreg`, `cnt` and `done` clear to 0.
  - Outputs after reset: `sout`=0, `sout_valid`=0, `done`=0, `load_ready`=1.
  - `load_ready` is forced to 0 while `rst` is high.
- IDLE:
  - `load_ready`=1, `sout_valid`=0, `sout`=0.
  - On `load_valid` high: `sreg` takes `din`, `cnt` takes 0, state goes to SHIFT.
  - `enable` is ignored.
- SHIFT:
  - `load_ready`=0, `sout_valid`=1, `sout`=`sreg[0]`.
  - When `enable` is high: `sreg` shifts right with 0 entering the MSB, and `cnt` increments.
  - When `enable` is high and `cnt` = WIDTH-1: state goes to IDLE and `done` is set for the next cycle.
  - When `enable` is low: `sreg`, `cnt` and `sout` all hold.
- `load_valid` during SHIFT is ignored; there is no buffering.
- `done` is cleared every cycle in which it is not being set.
- Reset mid-frame aborts the frame immediately. No `done` is produced, and partial bits are discarded.
- Pairing rule:
  - The receiver sees exactly WIDTH edges with `sout_valid & enable`.
  - After those edges, the receiver's parallel output equals the accepted `din`.

## Timing
- Load acceptance: at the edge where `load_valid & load_ready` are both high.
- First-bit latency: 1 cycle. In the cycle after acceptance, `sout_valid`=1 and `sout`=`din[0]`.
- Bit k (`din[k]`) is held on `sout` from the edge consuming bit k-1 until the edge consuming bit k.
- `done` is high for exactly one cycle, the cycle after the edge that consumes bit WIDTH-1.
  - In that same cycle, `sout_valid`=0 and `load_ready`=1.
- A load may be accepted in the `done` cycle.
- Minimum frame period is WIDTH+1 cycles with `enable` held high. This leaves one idle cycle of `sout_valid`=0 between back-to-back frames.
- `sout`, `sout_valid` and `done` are registered. `load_ready` is decoded from state and `rst` only, with no combinational path from `load_valid`.

## Structure
- Shared package `piso_pkg`:
  - state encoding constants `ST_IDLE`=1'b0 and `ST_SHIFT`=1'b1
  - default-width constant `SER_WIDTH`=4, shared with `sipo` benches
- Single module; no sub-module is natural. The counter and shift register are each a few lines.
- The test bench instantiates `sipo` as the receiving model, with `sin`=`sout` and `enable`=`sout_valid & enable`.

## Test plan
All scenarios use WIDTH=4.
- **Reset:** hold `rst` for 2 cycles → `sout`=0, `sout_valid`=0, `done`=0, `load_ready`=1 afterwards.
- **Basic frame:** load 4'b1011 with `enable` held at 1 → `sout` reads 1,1,0,1 on 4 consecutive cycles, `done` pulses once, and the paired `sipo` outputs 4'b1011.
- **Gated enable:** load 4'hA with `enable` pattern 1,0,0,1,1,0,1 → `sout` holds while `enable`=0, `done` appears after the 4th enabled edge, and `sipo` outputs 4'hA.
- **Load while busy:** `load_valid` with `din`=4'h5 during a 4'h3 frame → the load is ignored, `sipo` outputs 4'h3, and no extra frame is sent.
- **Reset mid-frame:** assert `rst` after 2 bits → `sout_valid`=0 the next cycle, `done` is never asserted, and `load_ready`=1 once `rst` is released.
- **Back-to-back:** `load_valid` held high with 4'h3 then 4'hC → frames are WIDTH+1=5 cycles apart, and `sipo` outputs 4'h3 then 4'hC.
